// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: one-cycle compute into a 2-entry FIFO output buffer.
// Accepts over valid/ready, absorbs downstream back-pressure, streams 1 op/cycle.
module alu_exec_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned ShW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OpAnd = 3'b000,
        OpOr  = 3'b001,
        OpAdd = 3'b010,
        OpXor = 3'b011,
        OpNor = 3'b100,
        OpSrl = 3'b101,
        OpSub = 3'b110,
        OpSlt = 3'b111
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ovf;
    } entry_t;

    logic [1:0] count_q, count_d;
    entry_t     ent0_q, ent0_d;
    entry_t     ent1_q, ent1_d;
    logic       in_ready_q;

    logic [WIDTH-1:0] sum, diff;
    logic             lt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    entry_t           alu_ent;
    logic             push, pop;

    // ALU datapath
    always_comb begin
        sum     = A + B;
        diff    = A - B;
        lt      = $signed(A) < $signed(B);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_e'(op))
            OpAnd: alu_res = A & B;
            OpOr:  alu_res = A | B;
            OpAdd: begin
                alu_res = sum;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OpXor: alu_res = A ^ B;
            OpNor: alu_res = ~(A | B);
            OpSrl: alu_res = B >> A[ShW-1:0];
            OpSub: begin
                alu_res = diff;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            // Direct signed compare stays correct when A-B overflows.
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, lt};
            default: alu_res = '0;
        endcase
        alu_ent.res  = alu_res;
        alu_ent.zero = (alu_res == '0);
        alu_ent.ovf  = alu_ovf;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign res       = ent0_q.res;
    assign zero      = ent0_q.zero;
    assign overflow  = ent0_q.ovf;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    // Buffer next-state: entry 0 is always the head.
    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    ent0_d  = alu_ent;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    ent0_d = alu_ent;
                end else if (push) begin
                    ent1_d  = alu_ent;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    ent0_d  = ent1_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    // in_ready is registered from the next count so it never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            in_ready_q <= (count_d != 2'd2);
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: ALU vectors, back-pressure, streaming, reset flush.
module tb_alu_exec_stage;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        zero;
    logic        overflow;

    int n_total = 0;
    int n_bad   = 0;
    int sent;
    int got;
    logic [31:0] exp_q[$];

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_total++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single op into an empty buffer with the consumer ready.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ez,
                         input logic eo);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        op = o; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom);
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_res"}, res, er);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
        tick();
        check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; A = '0; B = '0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("rel_out_valid", {31'd0, out_valid}, 32'd0);

        do_op("and", OP_AND, 32'd7, 32'd5, 32'd5, 1'b0, 1'b0);
        do_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        do_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
        do_op("slt_neg", OP_SLT, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0);
        do_op("xor_zero", OP_XOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        do_op("srl", OP_SRL, 32'd4, 32'hF000_0000, 32'h0F00_0000, 1'b0, 1'b0);
        do_op("nor", OP_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("or", OP_OR, 32'd1, 32'd8, 32'd9, 1'b0, 1'b0);
        do_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        do_op("sub_eq", OP_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
        do_op("slt_ovfcase", OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
        do_op("sub_ovf2", OP_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
        do_op("and_ovf0", OP_AND, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        // Back-pressure: 2, 4, then 9 must wait for space.
        out_ready = 1'b0;
        op = OP_ADD; A = 32'd1; B = 32'd1; in_valid = 1'b1;
        tick();
        check("bp_rdy1", {31'd0, in_ready}, 32'd1);
        check("bp_head1", res, 32'd2);
        op = OP_ADD; A = 32'd2; B = 32'd2;
        tick();
        check("bp_full", {31'd0, in_ready}, 32'd0);
        op = OP_OR; A = 32'd1; B = 32'd8;
        tick();
        check("bp_stall_rdy", {31'd0, in_ready}, 32'd0);
        check("bp_hold_a", res, 32'd2);
        tick();
        check("bp_hold_b", res, 32'd2);
        check("bp_hold_vld", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_pop1", res, 32'd4);
        check("bp_rdy_back", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_pop2", res, 32'd9);
        check("bp_pop2_vld", {31'd0, out_valid}, 32'd1);
        tick();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Streaming with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            op = OP_ADD; A = 32'(i); B = 32'd100; in_valid = 1'b1;
            tick();
            check("str_rdy", {31'd0, in_ready}, 32'd1);
            check("str_vld", {31'd0, out_valid}, 32'd1);
            check("str_res", res, 32'(i) + 32'd100);
        end
        in_valid = 1'b0;
        tick();
        check("str_empty", {31'd0, out_valid}, 32'd0);

        // Consumer toggles every cycle; reference queue tracks expected order.
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
            out_ready = ((cyc % 2) == 1);
            if (sent < 16) begin
                in_valid = 1'b1;
                op = (sent % 2 == 0) ? OP_ADD : OP_XOR;
                A = 32'(sent) * 32'h0101_0101;
                B = 32'h0F0F_0000 + 32'(sent);
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back((op == OP_ADD) ? (A + B) : (A ^ B));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("tog_extra", 32'd1, 32'd0);
                else check("tog_res", res, exp_q.pop_front());
                got++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("tog_sent", 32'(sent), 32'd16);
        check("tog_got", 32'(got), 32'd16);
        check("tog_empty", {31'd0, out_valid}, 32'd0);

        // Reset with two entries buffered, and an accept attempted in the reset cycle.
        out_ready = 1'b0;
        op = OP_ADD; A = 32'd1; B = 32'd2; in_valid = 1'b1;
        tick();
        A = 32'd3; B = 32'd4;
        tick();
        check("rf_full", {31'd0, in_ready}, 32'd0);
        check("rf_head", res, 32'd3);
        rst_n = 1'b0; op = OP_AND; A = 32'd7; B = 32'd5;
        tick();
        check("rf_vld", {31'd0, out_valid}, 32'd0);
        check("rf_res", res, 32'd0);
        check("rf_rdy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        check("rf_rel_rdy", {31'd0, in_ready}, 32'd1);
        check("rf_rel_vld", {31'd0, out_valid}, 32'd0);
        do_op("rf_and", OP_AND, 32'd7, 32'd5, 32'd5, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
